// File: rtl/hazard_unit_if.sv
// hazard_unit_if: pipeline hazard status in, latch enables/flushes out.
// The core side uses the master modport and the hazard unit uses the slave modport.
interface hazard_unit_if;
    logic       ihit;
    logic       dhit;
    logic       mem_dREN;
    logic       mem_dWEN;
    logic       ex_dREN;
    logic [4:0] ex_rd;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       id_useRt;
    logic       ex_redirect;
    logic       wb_halt;

    logic       pcEN;
    logic       ifid_EN;
    logic       idex_EN;
    logic       exmem_EN;
    logic       memwb_EN;
    logic       ifid_flush;
    logic       idex_flush;
    logic       exmem_flush;
    logic       halt;
    logic [1:0] state;

    modport master (
        output ihit, dhit, mem_dREN, mem_dWEN, ex_dREN, ex_rd, id_rs, id_rt,
               id_useRt, ex_redirect, wb_halt,
        input  pcEN, ifid_EN, idex_EN, exmem_EN, memwb_EN,
               ifid_flush, idex_flush, exmem_flush, halt, state
    );

    modport slave (
        input  ihit, dhit, mem_dREN, mem_dWEN, ex_dREN, ex_rd, id_rs, id_rt,
               id_useRt, ex_redirect, wb_halt,
        output pcEN, ifid_EN, idex_EN, exmem_EN, memwb_EN,
               ifid_flush, idex_flush, exmem_flush, halt, state
    );
endinterface

// File: rtl/hazard_unit.sv
// hazard_unit: stall/flush controller for the five-stage pipeline.
// Optional HAZARD_PERF_EN adds four 32-bit event counters.
//
// state  | meaning
// RUN    | normal flow; enables come from redirect/load-use/ifetch rules
// DWAIT  | MEM-stage data access outstanding; whole pipe frozen until dhit
// HALTED | halt reached WB; pipe frozen until reset
module hazard_unit (
    input  logic          CLK,
    input  logic          nRST,
    hazard_unit_if.slave  hz
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0]   stall_cnt,
    output logic [31:0]   lu_cnt,
    output logic [31:0]   flush_cnt,
    output logic [31:0]   if_cnt
`endif
);
    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DWAIT  = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t state_q, state_d;
    logic   halt_q;
    logic   mem_req;
    logic   rule_halt, rule_dwait, rule_redir, rule_lu, rule_ifw;
    logic   pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic   ifid_fl, idex_fl;

    assign mem_req = hz.mem_dREN | hz.mem_dWEN;

    // State and halt registers.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= RUN;
            halt_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            halt_q  <= halt_q | hz.wb_halt;
        end
    end

    // Next-state: halt overrides everything and is sticky.
    always_comb begin
        state_d = state_q;
        if (state_q == HALTED || hz.wb_halt) begin
            state_d = HALTED;
        end else begin
            case (state_q)
                RUN:     if (mem_req && !hz.dhit) state_d = DWAIT;
                DWAIT:   if (hz.dhit)             state_d = RUN;
                default: state_d = state_q;
            endcase
        end
    end

    // Rule selection in priority order; exactly one rule (or none) is active.
    always_comb begin
        rule_halt  = 1'b0;
        rule_dwait = 1'b0;
        rule_redir = 1'b0;
        rule_lu    = 1'b0;
        rule_ifw   = 1'b0;
        if (state_q == HALTED || hz.wb_halt) begin
            rule_halt = 1'b1;
        end else if ((state_q == DWAIT || mem_req) && !hz.dhit) begin
            rule_dwait = 1'b1;
        end else if (hz.ex_redirect) begin
            rule_redir = 1'b1;
        end else if (hz.ex_dREN && hz.ex_rd != 5'd0 &&
                     (hz.ex_rd == hz.id_rs || (hz.id_useRt && hz.ex_rd == hz.id_rt))) begin
            rule_lu = 1'b1;
        end else if (!hz.ihit) begin
            rule_ifw = 1'b1;
        end
    end

    // Enable/flush decode; everything is held low while reset is asserted.
    always_comb begin
        pc_en    = 1'b0;
        ifid_en  = 1'b0;
        idex_en  = 1'b0;
        exmem_en = 1'b0;
        memwb_en = 1'b0;
        ifid_fl  = 1'b0;
        idex_fl  = 1'b0;
        if (nRST && !rule_halt && !rule_dwait) begin
            ifid_en  = !rule_lu;
            idex_en  = 1'b1;
            exmem_en = 1'b1;
            memwb_en = 1'b1;
            pc_en    = rule_redir || (!rule_lu && !rule_ifw);
            ifid_fl  = rule_redir || rule_ifw;
            idex_fl  = rule_redir || rule_lu;
        end
    end

    assign hz.pcEN        = pc_en;
    assign hz.ifid_EN     = ifid_en;
    assign hz.idex_EN     = idex_en;
    assign hz.exmem_EN    = exmem_en;
    assign hz.memwb_EN    = memwb_en;
    assign hz.ifid_flush  = ifid_fl;
    assign hz.idex_flush  = idex_fl;
    assign hz.exmem_flush = 1'b0;
    assign hz.halt        = halt_q;
    assign hz.state       = state_q;

`ifdef HAZARD_PERF_EN
    // Event counters; rule_halt covers the HALTED freeze since no other rule fires then.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            stall_cnt <= 32'd0;
            lu_cnt    <= 32'd0;
            flush_cnt <= 32'd0;
            if_cnt    <= 32'd0;
        end else if (state_q != HALTED) begin
            if (rule_dwait) stall_cnt <= stall_cnt + 32'd1;
            if (rule_lu)    lu_cnt    <= lu_cnt + 32'd1;
            if (rule_redir) flush_cnt <= flush_cnt + 32'd1;
            if (rule_ifw)   if_cnt    <= if_cnt + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_hazard_unit.sv
// Directed self-checking bench for hazard_unit.
// Output vector order: {pcEN, ifid_EN, idex_EN, exmem_EN, memwb_EN, ifid_flush, idex_flush, exmem_flush}
module tb_hazard_unit;
    logic CLK = 1'b0;
    logic nRST = 1'b0;
    int   checks = 0;
    int   errors = 0;

    localparam logic [7:0] O_DEF   = 8'b11111_000;
    localparam logic [7:0] O_FRZ   = 8'b00000_000;
    localparam logic [7:0] O_REDIR = 8'b11111_110;
    localparam logic [7:0] O_LU    = 8'b00111_010;
    localparam logic [7:0] O_IFW   = 8'b01111_100;

    hazard_unit_if hif ();

`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cnt, lu_cnt, flush_cnt, if_cnt;
`endif

    hazard_unit dut (
        .CLK  (CLK),
        .nRST (nRST),
        .hz   (hif)
`ifdef HAZARD_PERF_EN
        ,
        .stall_cnt (stall_cnt),
        .lu_cnt    (lu_cnt),
        .flush_cnt (flush_cnt),
        .if_cnt    (if_cnt)
`endif
    );

    logic [7:0] outs;
    assign outs = {hif.pcEN, hif.ifid_EN, hif.idex_EN, hif.exmem_EN, hif.memwb_EN,
                   hif.ifid_flush, hif.idex_flush, hif.exmem_flush};

    always #5 CLK = ~CLK;

    task automatic idle_inputs();
        hif.ihit = 1'b1;  hif.dhit = 1'b1;
        hif.mem_dREN = 1'b0; hif.mem_dWEN = 1'b0;
        hif.ex_dREN = 1'b0; hif.ex_rd = 5'd0;
        hif.id_rs = 5'd0; hif.id_rt = 5'd0; hif.id_useRt = 1'b0;
        hif.ex_redirect = 1'b0; hif.wb_halt = 1'b0;
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        nRST = 1'b0;
        idle_inputs();
        hif.ex_redirect = 1'b1;
        #2;
        checks++;
        if (outs !== O_FRZ) begin errors++; $display("FAIL reset_outs got %b want %b", outs, O_FRZ); end
        checks++;
        if (hif.state !== 2'd0 || hif.halt !== 1'b0) begin
            errors++; $display("FAIL reset_state got state=%0d halt=%b want 0 0", hif.state, hif.halt);
        end
`ifdef HAZARD_PERF_EN
        checks++;
        if ({stall_cnt, lu_cnt, flush_cnt, if_cnt} !== 128'd0) begin
            errors++; $display("FAIL reset_cnt got %h want 0", {stall_cnt, lu_cnt, flush_cnt, if_cnt});
        end
`endif
        next_cycle();
        nRST = 1'b1;
        idle_inputs();
        #2;
        checks++;
        if (outs !== O_DEF) begin errors++; $display("FAIL post_reset_default got %b want %b", outs, O_DEF); end
    endtask

    task automatic test_load_use();
        next_cycle();
        hif.ex_dREN = 1'b1; hif.ex_rd = 5'd5; hif.id_rs = 5'd5;
        #2;
        checks++;
        if (outs !== O_LU) begin errors++; $display("FAIL lu_rs got %b want %b", outs, O_LU); end
        next_cycle();
        hif.ex_dREN = 1'b0; hif.ex_rd = 5'd0;
        #2;
        checks++;
        if (outs !== O_DEF) begin errors++; $display("FAIL lu_bubble_next got %b want %b", outs, O_DEF); end
        next_cycle();
        hif.ex_dREN = 1'b1; hif.ex_rd = 5'd0; hif.id_rs = 5'd0; hif.id_rt = 5'd0; hif.id_useRt = 1'b1;
        #2;
        checks++;
        if (outs !== O_DEF) begin errors++; $display("FAIL lu_r0 got %b want %b", outs, O_DEF); end
        next_cycle();
        hif.ex_rd = 5'd5; hif.id_rs = 5'd3; hif.id_rt = 5'd5; hif.id_useRt = 1'b0;
        #2;
        checks++;
        if (outs !== O_DEF) begin errors++; $display("FAIL lu_rt_unused got %b want %b", outs, O_DEF); end
        hif.id_useRt = 1'b1;
        #1;
        checks++;
        if (outs !== O_LU) begin errors++; $display("FAIL lu_rt_used got %b want %b", outs, O_LU); end
        next_cycle();
        idle_inputs();
    endtask

    task automatic test_ifetch_wait();
        next_cycle();
        hif.ihit = 1'b0;
        #2;
        checks++;
        if (outs !== O_IFW) begin errors++; $display("FAIL ifetch_wait got %b want %b", outs, O_IFW); end
        next_cycle();
        idle_inputs();
    endtask

    task automatic test_load_miss();
        next_cycle();
        hif.mem_dREN = 1'b1; hif.dhit = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #2;
            checks++;
            if (outs !== O_FRZ || hif.state !== ((c == 0) ? 2'd0 : 2'd1)) begin
                errors++; $display("FAIL miss_cycle%0d got outs=%b state=%0d", c, outs, hif.state);
            end
            next_cycle();
        end
        hif.dhit = 1'b1;
        #2;
        checks++;
        if (outs !== O_DEF || hif.state !== 2'd1) begin
            errors++; $display("FAIL miss_dhit got outs=%b state=%0d want %b 1", outs, hif.state, O_DEF);
        end
        next_cycle();
        hif.mem_dREN = 1'b0;
        #2;
        checks++;
        if (hif.state !== 2'd0) begin errors++; $display("FAIL miss_return got state=%0d want 0", hif.state); end
        hif.mem_dWEN = 1'b1; hif.dhit = 1'b1;
        #1;
        checks++;
        if (outs !== O_DEF) begin errors++; $display("FAIL hit_same_cycle got %b want %b", outs, O_DEF); end
        next_cycle();
        checks++;
        if (hif.state !== 2'd0) begin errors++; $display("FAIL hit_no_dwait got state=%0d want 0", hif.state); end
        idle_inputs();
    endtask

    task automatic test_redirect_combo();
`ifdef HAZARD_PERF_EN
        logic [31:0] f0, l0;
`endif
        next_cycle();
        hif.ex_redirect = 1'b1; hif.ihit = 1'b0;
        hif.ex_dREN = 1'b1; hif.ex_rd = 5'd7; hif.id_rs = 5'd7;
        #2;
        checks++;
        if (outs !== O_REDIR) begin errors++; $display("FAIL redirect_combo got %b want %b", outs, O_REDIR); end
`ifdef HAZARD_PERF_EN
        f0 = flush_cnt; l0 = lu_cnt;
`endif
        next_cycle();
        idle_inputs();
`ifdef HAZARD_PERF_EN
        checks++;
        if (flush_cnt !== f0 + 32'd1 || lu_cnt !== l0) begin
            errors++; $display("FAIL redirect_cnt got flush=%0d lu=%0d want %0d %0d", flush_cnt, lu_cnt, f0 + 32'd1, l0);
        end
`endif
    endtask

    task automatic test_redirect_dwait();
        next_cycle();
        hif.mem_dREN = 1'b1; hif.dhit = 1'b0; hif.ex_redirect = 1'b1;
        for (int c = 0; c < 2; c++) begin
            #2;
            checks++;
            if (outs !== O_FRZ) begin errors++; $display("FAIL redir_dwait_cycle%0d got %b want %b", c, outs, O_FRZ); end
            next_cycle();
        end
        hif.dhit = 1'b1;
        #2;
        checks++;
        if (outs !== O_REDIR) begin errors++; $display("FAIL redir_dwait_dhit got %b want %b", outs, O_REDIR); end
        next_cycle();
        idle_inputs();
    endtask

    task automatic test_halt();
        next_cycle();
        hif.wb_halt = 1'b1;
        #2;
        checks++;
        if (outs !== O_FRZ || hif.halt !== 1'b0) begin
            errors++; $display("FAIL halt_pulse got outs=%b halt=%b want %b 0", outs, hif.halt, O_FRZ);
        end
        next_cycle();
        hif.wb_halt = 1'b0;
        #2;
        checks++;
        if (hif.halt !== 1'b1 || hif.state !== 2'd2 || outs !== O_FRZ) begin
            errors++; $display("FAIL halt_set got halt=%b state=%0d outs=%b want 1 2 0", hif.halt, hif.state, outs);
        end
        next_cycle();
        next_cycle();
        checks++;
        if (hif.halt !== 1'b1 || hif.state !== 2'd2) begin
            errors++; $display("FAIL halt_sticky got halt=%b state=%0d want 1 2", hif.halt, hif.state);
        end
    endtask

    task automatic test_reset_mid_dwait();
        nRST = 1'b0;
        #2;
        nRST = 1'b1;
        next_cycle();
        hif.mem_dREN = 1'b1; hif.dhit = 1'b0; hif.ihit = 1'b1;
        next_cycle();
        #2;
        checks++;
        if (hif.state !== 2'd1) begin errors++; $display("FAIL pre_reset_dwait got state=%0d want 1", hif.state); end
        nRST = 1'b0;
        #1;
        checks++;
        if (hif.state !== 2'd0 || hif.halt !== 1'b0 || outs !== O_FRZ) begin
            errors++; $display("FAIL reset_mid_dwait got state=%0d halt=%b outs=%b want 0 0 0", hif.state, hif.halt, outs);
        end
`ifdef HAZARD_PERF_EN
        checks++;
        if ({stall_cnt, lu_cnt, flush_cnt, if_cnt} !== 128'd0) begin
            errors++; $display("FAIL reset_mid_cnt got %h want 0", {stall_cnt, lu_cnt, flush_cnt, if_cnt});
        end
`endif
        next_cycle();
        idle_inputs();
        nRST = 1'b1;
        next_cycle();
        #2;
        checks++;
        if (hif.state !== 2'd0 || outs !== O_DEF) begin
            errors++; $display("FAIL after_reset_run got state=%0d outs=%b want 0 %b", hif.state, outs, O_DEF);
        end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_load_use();
        test_ifetch_wait();
        test_load_miss();
        test_redirect_combo();
        test_redirect_dwait();
        test_halt();
        test_reset_mid_dwait();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end
endmodule
